bus_breakout_arb: RTL

BUS_BREAKOUT_ARB -- requirements
Module: bus_breakout_arb

---
 rtl/bus_breakout_arb.sv | 85 ++++++++
 1 files changed

// File: rtl/bus_breakout_arb.sv
// rtl/bus_breakout_arb.sv - two-requester round-robin arbiter feeding one 6-bit shared bus word
module bus_breakout_arb #(
    parameter int PARK = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_1,
    input  logic [3:0] in_1,
    output logic       ack_1,
    input  logic       req_2,
    input  logic [3:0] in_2,
    output logic       ack_2,
    output logic [5:0] out_1,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] xfer_cnt
);

    typedef enum logic {IDLE, XFER} state_t;

    state_t state, state_nxt;
    logic   prefer_2;
    logic   elig_1, elig_2;
    logic   accept, can_capture;
    logic   grant_1, grant_2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        grant_1     = 1'b0;
        grant_2     = 1'b0;
        // A requester whose ack is showing this cycle has already been served.
        elig_1      = req_1 && !ack_1;
        elig_2      = req_2 && !ack_2;
        accept      = (state == XFER) && out_ready;
        can_capture = (state == IDLE) || out_ready;
        if (can_capture) begin
            if (elig_1 && elig_2) begin
                grant_2 = prefer_2;
                grant_1 = !prefer_2;
            end else begin
                grant_1 = elig_1;
                grant_2 = elig_2;
            end
        end
        if (grant_1 || grant_2) begin
            state_nxt = XFER;
        end else if (accept) begin
            state_nxt = IDLE;
        end
    end

    assign out_valid = (state == XFER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_1    <= 6'b000000;
            ack_1    <= 1'b0;
            ack_2    <= 1'b0;
            xfer_cnt <= 8'd0;
            prefer_2 <= (PARK != 0);
        end else begin
            ack_1 <= grant_1;
            ack_2 <= grant_2;
            if (accept) begin
                xfer_cnt <= xfer_cnt + 8'd1;
            end
            if (grant_1) begin
                out_1    <= {2'b01, in_1};
                prefer_2 <= 1'b1;
            end else if (grant_2) begin
                out_1    <= {2'b10, in_2};
                prefer_2 <= 1'b0;
            end
        end
    end

endmodule
